fetch_redirect_unit: RTL and testbench

//   IF stage of the 5-stage MIPS pipeline: owns the PC, drives instruction-memory address,

---
 rtl/fetch_redirect_unit.sv | 117 +++++++++++
 tb/tb_fetch_redirect_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - IF stage: PC, IF/ID latch, bne/j redirect with one-bubble squash.
// Optional branch statistics counters enabled by defining BRANCH_STATS_EN.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Taken,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IMem_Addr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Redirect,
  output logic [31:0] BrCount,
  output logic [31:0] TakenCount
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        is_jump;

  assign pc_plus4 = pc_q + 32'd4;
  assign is_jump  = (instr_q[31:26] == 6'b000010);
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign target   = is_jump ? {pcp4_q[31:28], instr_q[25:0], 2'b00} : (pcp4_q + br_off);

  // Only RUN can hold a valid instruction; BOOT and FLUSH always present a bubble.
  assign Redirect = Branch & Taken & valid_q & ~Stall & (state_q == RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (!Stall) begin
      if (Redirect) begin
        state_d = FLUSH;
        pc_d    = target;
        instr_d = NOP_INSTR;
        pcp4_d  = 32'h0;
        valid_d = 1'b0;
      end else begin
        state_d = RUN;
        pc_d    = pc_plus4;
        instr_d = IMem_Data;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign IMem_Addr     = pc_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCPlus4 = pcp4_q;
  assign IF_ID_Valid   = valid_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] tk_cnt_q, tk_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (Branch && valid_q && !Stall && (br_cnt_q != 32'hFFFF_FFFF))
      br_cnt_d = br_cnt_q + 32'd1;
    if (Redirect && (tk_cnt_q != 32'hFFFF_FFFF))
      tk_cnt_d = tk_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      br_cnt_q <= 32'h0;
      tk_cnt_q <= 32'h0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign BrCount    = br_cnt_q;
  assign TakenCount = tk_cnt_q;
`else
  assign BrCount    = 32'h0;
  assign TakenCount = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - scoreboard bench for fetch_redirect_unit (RESET_PC near wrap).
module tb_fetch_redirect_unit;

  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk, Rst, Stall, Branch, Taken;
  logic [31:0] IMem_Data, IMem_Addr, IF_ID_Instr, IF_ID_PCPlus4, BrCount, TakenCount;
  logic        IF_ID_Valid, Redirect;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        v;
    logic        r;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  fetch_redirect_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Branch(Branch), .Taken(Taken),
    .IMem_Data(IMem_Data), .IMem_Addr(IMem_Addr), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid), .Redirect(Redirect),
    .BrCount(BrCount), .TakenCount(TakenCount)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_001C: imem = 32'h1400_FFFE;
      32'h0000_0018: imem = 32'h0BFF_FFFE;
      32'h1000_000C: imem = 32'h0800_0040;
      32'h1000_0100: imem = 32'h1400_0004;
      32'h1000_0114: imem = 32'h1400_0004;
      default:       imem = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign IMem_Data = imem(IMem_Addr);

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc%0d got %h expected %h", name, c, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr", e.cyc, IMem_Addr, e.addr);
      chk("if_id_valid", e.cyc, {31'h0, IF_ID_Valid}, {31'h0, e.v});
      chk("if_id_pcplus4", e.cyc, IF_ID_PCPlus4, e.p4);
      chk("if_id_instr", e.cyc, IF_ID_Instr, e.instr);
      chk("redirect", e.cyc, {31'h0, Redirect}, {31'h0, e.r});
    end
  end

  task automatic step(input logic rst, input logic st, input logic br, input logic tk,
                      input logic [31:0] addr, input logic v, input logic [31:0] p4, input logic r);
    exp_t e;
    @(posedge Clk);
    #1;
    Rst = rst; Stall = st; Branch = br; Taken = tk;
    e.cyc   = cyc;
    e.addr  = addr;
    e.v     = v;
    e.p4    = p4;
    e.instr = v ? imem(p4 - 32'd4) : NOP;
    e.r     = r;
    exp_q.push_back(e);
    cyc++;
  endtask

  initial begin
    int wait_cnt;
    logic [31:0] exp_br, exp_tk;
    Rst = 1'b0; Stall = 1'b0; Branch = 1'b1; Taken = 1'b1;
    repeat (3) step(0, 0, 1, 1, RPC, 0, 32'h0, 0);
    step(1, 1, 0, 0, RPC, 0, 32'h0, 0);
    step(1, 0, 0, 0, RPC, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_0000, 0);
    for (int a = 4; a <= 32'h1C; a += 4)
      step(1, 0, 0, 0, a, 1, a, 0);
    step(1, 0, 1, 1, 32'h20, 1, 32'h20, 1);
    step(1, 0, 1, 1, 32'h18, 0, 32'h0, 0);
    step(1, 0, 1, 1, 32'h1C, 1, 32'h1C, 1);
    step(1, 1, 0, 0, 32'h0FFF_FFF8, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0FFF_FFF8, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0FFF_FFFC, 1, 32'h0FFF_FFFC, 0);
    for (int a = 32'h1000_0000; a <= 32'h1000_000C; a += 4)
      step(1, 0, 0, 0, a, 1, a, 0);
    step(1, 0, 1, 1, 32'h1000_0010, 1, 32'h1000_0010, 1);
    step(1, 0, 0, 0, 32'h1000_0100, 0, 32'h0, 0);
    step(1, 1, 1, 1, 32'h1000_0104, 1, 32'h1000_0104, 0);
    step(1, 1, 1, 1, 32'h1000_0104, 1, 32'h1000_0104, 0);
    step(1, 0, 1, 1, 32'h1000_0104, 1, 32'h1000_0104, 1);
    step(1, 0, 0, 0, 32'h1000_0114, 0, 32'h0, 0);
    step(1, 0, 1, 0, 32'h1000_0118, 1, 32'h1000_0118, 0);
    step(1, 0, 0, 0, 32'h1000_011C, 1, 32'h1000_011C, 0);
    step(1, 0, 0, 0, 32'h1000_0120, 1, 32'h1000_0120, 0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge Clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end

`ifdef BRANCH_STATS_EN
    exp_br = 32'd5;
    exp_tk = 32'd4;
`else
    exp_br = 32'd0;
    exp_tk = 32'd0;
`endif
    #2;
    chk("br_count", cyc, BrCount, exp_br);
    chk("taken_count", cyc, TakenCount, exp_tk);

    @(posedge Clk);
    #3;
    Rst = 1'b0;
    #1;
    chk("rst_addr", cyc, IMem_Addr, RPC);
    chk("rst_valid", cyc, {31'h0, IF_ID_Valid}, 32'h0);
    chk("rst_pcplus4", cyc, IF_ID_PCPlus4, 32'h0);
    chk("rst_instr", cyc, IF_ID_Instr, NOP);
    chk("rst_redirect", cyc, {31'h0, Redirect}, 32'h0);
    chk("rst_br_count", cyc, BrCount, 32'h0);
    chk("rst_taken_count", cyc, TakenCount, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
